ram64m_reader: RTL and testbench

RAM64M_READER -- requirements
Module: ram64m_reader

---
 rtl/ram64m_reader.sv | 73 +++++++
 tb/tb_ram64m_reader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram64m_reader.sv
// ram64m_reader: streams a burst of words from an asynchronous-read RAM64M into a valid/ready stream,
// stalling reads that collide with an in-flight write so the post-write value is captured.
module ram64m_reader #(
  parameter logic IS_CLK_INVERTED = 1'b0,
  parameter logic STALL_ON_HAZARD = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [5:0] START_ADDR,
  input  logic [6:0] COUNT,
  output logic [5:0] RADDR,
  input  logic [3:0] RDATA,
  input  logic       WE_MON,
  input  logic [5:0] WADDR_MON,
  output logic       M_VALID,
  input  logic       M_READY,
  output logic [3:0] M_DATA,
  output logic [5:0] M_ADDR,
  output logic       M_LAST,
  output logic       BUSY,
  output logic       DONE
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t     r_state, w_next;
  logic [6:0] r_rem;
  logic       w_clk, w_xfer, w_hazard, w_cap, w_start;
  assign w_clk    = CLK ^ IS_CLK_INVERTED;
  assign w_xfer   = M_VALID & M_READY;
  assign w_hazard = STALL_ON_HAZARD & WE_MON & (WADDR_MON == RADDR);
  assign w_cap    = (r_state == RUN) & (~M_VALID | M_READY) & ~w_hazard;
  assign w_start  = (r_state == IDLE) & START;
  always_ff @(posedge w_clk)
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_start && COUNT != 7'd0) ? RUN : IDLE;
      RUN:     w_next = (w_cap && r_rem == 7'd1) ? DRAIN : RUN;
      DRAIN:   w_next = w_xfer ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_comb BUSY = r_state != IDLE;
  // Output register doubles as the one-deep skid; it refills on the same edge it drains.
  always_ff @(posedge w_clk) begin
    if (RST) begin
      RADDR   <= '0;
      r_rem   <= '0;
      M_VALID <= 1'b0;
      M_DATA  <= '0;
      M_ADDR  <= '0;
      M_LAST  <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      if (w_start) begin
        RADDR <= START_ADDR;
        r_rem <= COUNT;
      end else if (w_cap) begin
        RADDR <= RADDR + 6'd1;
        r_rem <= r_rem - 7'd1;
      end
      if (w_cap) begin
        M_DATA  <= RDATA;
        M_ADDR  <= RADDR;
        M_LAST  <= r_rem == 7'd1;
        M_VALID <= 1'b1;
      end else if (w_xfer) M_VALID <= 1'b0;
      DONE <= (w_start && COUNT == 7'd0) || (w_xfer && M_LAST);
    end
  end
endmodule

// File: tb/tb_ram64m_reader.sv
// tb_ram64m_reader: directed bench with a RAM64M model and a beat scoreboard.
module tb_ram64m_reader;
  logic       CLK = 1'b0, RST = 1'b1, START = 1'b0, WE_MON = 1'b0, M_READY = 1'b0;
  logic [5:0] START_ADDR = '0, WADDR_MON = '0;
  logic [6:0] COUNT = '0;
  logic [5:0] RADDR, M_ADDR;
  logic [3:0] RDATA, M_DATA, wdata = '0;
  logic       M_VALID, M_LAST, BUSY, DONE;
  logic [3:0] mem [64];
  logic [10:0] q[$];
  int total = 0, passed = 0, fails = 0, done_seen = 0;
  logic mon_en = 1'b0, p_hold = 1'b0, p_last = 1'b0, p_zero = 1'b0;
  logic [10:0] p_beat = '0;

  ram64m_reader dut (
    .CLK(CLK), .RST(RST), .START(START), .START_ADDR(START_ADDR), .COUNT(COUNT),
    .RADDR(RADDR), .RDATA(RDATA), .WE_MON(WE_MON), .WADDR_MON(WADDR_MON),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_ADDR(M_ADDR),
    .M_LAST(M_LAST), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;
  assign RDATA = mem[RADDR];
  always @(posedge CLK) if (WE_MON) mem[WADDR_MON] <= wdata;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_burst(input logic [5:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      logic [5:0] x;
      x = a + 6'(k);
      q.push_back({x, mem[x], k == n - 1});
    end
  endtask

  task automatic start_burst(input logic [5:0] a, input logic [6:0] n);
    START_ADDR = a;
    COUNT = n;
    START = 1'b1;
    tick;
    START = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (BUSY && n < 200) begin
      tick;
      n++;
    end
    chk("idle_timeout", BUSY, 0);
    tick;
  endtask

  // Monitor: scoreboard pops, stability while stalled, and exact DONE timing.
  always @(negedge CLK) if (mon_en) begin
    if (p_hold) begin
      chk("hold_valid", M_VALID, 1);
      chk("hold_data", {M_ADDR, M_DATA, M_LAST}, p_beat);
    end
    chk("done", DONE, p_last | p_zero);
    if (M_VALID && M_READY && !RST) begin
      if (q.size() == 0) chk("extra_beat", {M_ADDR, M_DATA, M_LAST}, 11'h7ff ^ {M_ADDR, M_DATA, M_LAST});
      else chk("beat", {M_ADDR, M_DATA, M_LAST}, q.pop_front());
    end
    if (DONE) done_seen++;
    p_hold = M_VALID && !M_READY && !RST;
    p_beat = {M_ADDR, M_DATA, M_LAST};
    p_last = M_VALID && M_READY && M_LAST && !RST;
    p_zero = START && COUNT == 7'd0 && !BUSY && !RST;
  end

  initial begin
    int d0;
    for (int i = 0; i < 64; i++) mem[i] = 4'(i);
    tick;
    tick;
    chk("rst_raddr", RADDR, 0);
    chk("rst_valid", M_VALID, 0);
    chk("rst_data", M_DATA, 0);
    chk("rst_addr", M_ADDR, 0);
    chk("rst_last", M_LAST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    RST = 1'b0;
    mon_en = 1'b1;
    // Basic burst with full throughput and first-beat latency.
    M_READY = 1'b1;
    d0 = done_seen;
    push_burst(6'd5, 4);
    start_burst(6'd5, 7'd4);
    chk("b1_busy", BUSY, 1);
    chk("b1_raddr", RADDR, 5);
    chk("b1_valid0", M_VALID, 0);
    tick;
    chk("b1_valid1", M_VALID, 1);
    repeat (4) tick;
    chk("b1_end_busy", BUSY, 0);
    chk("b1_end_done", DONE, 1);
    tick;
    chk("b1_done_cnt", done_seen - d0, 1);
    // Address wrap.
    push_burst(6'd62, 4);
    start_burst(6'd62, 7'd4);
    wait_idle;
    // Backpressure on the first beat.
    M_READY = 1'b0;
    push_burst(6'd20, 3);
    start_burst(6'd20, 7'd3);
    tick;
    repeat (3) tick;
    chk("bp_data", M_DATA, 4);
    chk("bp_raddr", RADDR, 21);
    M_READY = 1'b1;
    wait_idle;
    // Write hazard at address 10 stalls one capture.
    q.push_back({6'd8, 4'h8, 1'b0});
    q.push_back({6'd9, 4'h9, 1'b0});
    q.push_back({6'd10, 4'hA, 1'b0});
    q.push_back({6'd11, 4'hB, 1'b1});
    start_burst(6'd8, 7'd4);
    for (int i = 0; i < 10 && RADDR != 6'd10; i++) tick;
    chk("hz_reach", RADDR, 10);
    WE_MON = 1'b1;
    WADDR_MON = 6'd10;
    wdata = 4'hA;
    tick;
    WE_MON = 1'b0;
    chk("hz_stall_raddr", RADDR, 10);
    chk("hz_stall_valid", M_VALID, 0);
    wait_idle;
    // Reset mid-burst after two beats.
    d0 = done_seen;
    push_burst(6'd30, 8);
    start_burst(6'd30, 7'd8);
    repeat (3) tick;
    chk("rs_q_left", q.size(), 6);
    RST = 1'b1;
    M_READY = 1'b0;
    START = 1'b1;
    tick;
    RST = 1'b0;
    START = 1'b0;
    M_READY = 1'b1;
    q.delete();
    chk("rs_valid", M_VALID, 0);
    chk("rs_busy", BUSY, 0);
    chk("rs_done", DONE, 0);
    repeat (3) tick;
    chk("rs_busy2", BUSY, 0);
    chk("rs_no_done", done_seen - d0, 0);
    push_burst(6'd0, 1);
    start_burst(6'd0, 7'd1);
    tick;
    chk("rs1_data", M_DATA, 0);
    chk("rs1_last", M_LAST, 1);
    wait_idle;
    // Zero-length command.
    d0 = done_seen;
    start_burst(6'd7, 7'd0);
    chk("z_busy", BUSY, 0);
    chk("z_valid", M_VALID, 0);
    chk("z_done", DONE, 1);
    tick;
    chk("z_done_off", DONE, 0);
    tick;
    chk("z_done_cnt", done_seen - d0, 1);
    // START while busy is ignored.
    push_burst(6'd40, 3);
    start_burst(6'd40, 7'd3);
    START_ADDR = 6'd50;
    COUNT = 7'd5;
    START = 1'b1;
    tick;
    START = 1'b0;
    chk("busy_start_raddr", RADDR, 41);
    wait_idle;
    chk("busy_start_busy", BUSY, 0);
    chk("q_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
